// File: rtl/branch_predictor_param_pkg.sv
// Shared types for the dynamic branch predictor: counter encodings, BTB entry, mode selectors.
// Pure declarations; no timing and no flow control.
package branch_predictor_param_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctrStateT;

  localparam int MODE_BIMODAL = 0;
  localparam int MODE_GSHARE  = 1;

  // Entry fields are sized for the widest supported configuration; narrower
  // instances zero-extend on write so the upper bits stay constant.
  localparam int BTB_TAG_MAX = 32;
  localparam int BTB_TGT_MAX = 64;

  typedef struct packed {
    logic                   valid;
    logic                   isJump;
    logic [BTB_TAG_MAX-1:0] tag;
    logic [BTB_TGT_MAX-1:0] target;
  } btbEntryT;

endpackage

// File: rtl/branch_predictor_param_sat_counter2.sv
// 2-bit saturating counter next-state function; purely combinational, zero latency.
// No handshake: the caller chooses when the result is written back.
module sat_counter2
  import branch_predictor_param_pkg::*;
(
  input  logic [1:0] cnt,
  input  logic       taken,
  output logic [1:0] cntNext
);

  always_comb begin
    cntNext = cnt;
    if (taken) begin
      if (cnt != ST) cntNext = cnt + 2'd1;
    end else if (cnt != SNT) begin
      cntNext = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor_param.sv
// Bimodal/gshare direction predictor with direct-mapped BTB; lookup and mispredict are combinational, training commits on clk.
// No backpressure: every upd_valid cycle is accepted; lookups never stall.
module branch_predictor_param
  import branch_predictor_param_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PHT_IDX = 6,
  parameter int BTB_IDX = 4,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 6,
  parameter int MODE    = 1,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_target_f,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_is_branch,
  input  logic            upd_is_jump,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_pred_taken,
  input  logic [XLEN-1:0] upd_pred_target,
  output logic            mispredict_e,
  output logic [XLEN-1:0] redirect_pc_e,
  output logic [CNT_W-1:0] stat_branches,
  output logic [CNT_W-1:0] stat_mispredicts
);

  localparam int PHT_N = 2 ** PHT_IDX;
  localparam int BTB_N = 2 ** BTB_IDX;

  logic     [PHT_N-1:0][1:0] pht;
  btbEntryT [BTB_N-1:0]      btb;
  logic [GHR_W-1:0]          ghr;
  logic [CNT_W-1:0]          branchCnt;
  logic [CNT_W-1:0]          mispCnt;

  function automatic logic [PHT_IDX-1:0] phtIndex(input logic [XLEN-1:0] pc,
                                                  input logic [GHR_W-1:0] hist);
    logic [PHT_IDX-1:0] idx;
    idx = pc[PHT_IDX+1:2];
    if (MODE == MODE_GSHARE) idx = idx ^ PHT_IDX'(hist);
    return idx;
  endfunction

  logic [BTB_IDX-1:0] lookBtbIdx, updBtbIdx;
  logic [TAG_W-1:0]   lookTag, updTag;
  logic [PHT_IDX-1:0] lookPhtIdx, updPhtIdx;
  btbEntryT           lookEntry;
  logic               lookHit;
  logic [1:0]         phtCur, phtNext;
  logic               writeBtb, killBtb;

  assign lookBtbIdx = pc_f[BTB_IDX+1:2];
  assign lookTag    = pc_f[TAG_W+BTB_IDX+1:BTB_IDX+2];
  assign lookPhtIdx = phtIndex(pc_f, ghr);
  assign lookEntry  = btb[lookBtbIdx];
  assign lookHit    = lookEntry.valid && (lookEntry.tag == BTB_TAG_MAX'(lookTag));

  // Jumps in the BTB redirect unconditionally; branches follow the PHT.
  assign pred_taken_f  = lookHit && (lookEntry.isJump || pht[lookPhtIdx][1]);
  assign pred_target_f = pred_taken_f ? XLEN'(lookEntry.target) : pc_f + XLEN'(4);

  assign updBtbIdx = upd_pc[BTB_IDX+1:2];
  assign updTag    = upd_pc[TAG_W+BTB_IDX+1:BTB_IDX+2];
  assign updPhtIdx = phtIndex(upd_pc, ghr);
  assign phtCur    = pht[updPhtIdx];

  sat_counter2 uPhtNext (
    .cnt     (phtCur),
    .taken   (upd_taken),
    .cntNext (phtNext)
  );

  assign mispredict_e  = upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc_e = upd_taken ? upd_target : upd_pc + XLEN'(4);

  assign writeBtb = (upd_is_branch && upd_taken) || upd_is_jump;
  // A non-control instruction that hit in the BTB is an alias; evict it.
  assign killBtb  = !upd_is_branch && !upd_is_jump && upd_pred_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pht       <= {PHT_N{WNT}};
      btb       <= '0;
      ghr       <= '0;
      branchCnt <= '0;
      mispCnt   <= '0;
    end else if (upd_valid) begin
      if (upd_is_branch) begin
        pht[updPhtIdx] <= phtNext;
        ghr            <= GHR_W'({ghr, upd_taken});
      end
      if (writeBtb) begin
        btb[updBtbIdx] <= '{valid:  1'b1,
                            isJump: upd_is_jump,
                            tag:    BTB_TAG_MAX'(updTag),
                            target: BTB_TGT_MAX'(upd_target)};
      end else if (killBtb) begin
        btb[updBtbIdx].valid <= 1'b0;
      end
      if ((upd_is_branch || upd_is_jump) && (branchCnt != '1))
        branchCnt <= branchCnt + CNT_W'(1);
      if (mispredict_e && (mispCnt != '1))
        mispCnt <= mispCnt + CNT_W'(1);
    end
  end

  assign stat_branches    = branchCnt;
  assign stat_mispredicts = mispCnt;

  logic unusedBits;
  assign unusedBits = ^{lookEntry, ghr};

endmodule
